// File: rtl/ucsbece154b_mem_responder.sv
// ucsbece154b_mem_responder
// Data-port responder for the pipelined core's M stage. Each load/store is
// serviced from an internal word array after a fixed, parameterized latency.
// Completion is signalled by a one-cycle ready_o pulse, and busy_o stalls the
// M stage until that pulse.
// Optional performance counters: define UCSBECE154B_MEM_PERF_EN.
module ucsbece154b_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
`ifdef UCSBECE154B_MEM_PERF_EN
    output logic [31:0] perf_req_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Byte span of the array. It is held in 33 bits so that the top of the
    // window cannot overflow.
    localparam logic [32:0] SPAN       = 33'd4 << ADDR_WIDTH;
    localparam bit          ZERO_LAT   = (LATENCY == 0);
    localparam int unsigned CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [31:0]            mem_q [2**ADDR_WIDTH];

    logic                   accept_c;
    logic                   commit_c;
    logic                   cur_we;
    logic [31:0]            cur_addr;
    logic [31:0]            cur_wdata;
    logic [3:0]             cur_be;
    logic [31:0]            off_c;
    logic                   err_c;
    logic [ADDR_WIDTH-1:0]  idx_c;
    logic [31:0]            rd_word_c;

    // Select the transaction being completed. With zero latency, completion
    // happens on the accepting edge, so the live inputs are used instead of
    // the latched copy.
    always_comb begin
        if (ZERO_LAT) begin
            cur_we    = we_i;
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
            cur_be    = be_i;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    // Decode the address. Subtraction wraps addresses below BASE_ADDR past the
    // span, so a single unsigned compare catches both ends of the window.
    always_comb begin
        off_c     = cur_addr - BASE_ADDR;
        err_c     = (off_c[1:0] != 2'b00) || ({1'b0, off_c} >= SPAN);
        idx_c     = off_c[ADDR_WIDTH+1:2];
        rd_word_c = mem_q[idx_c];
    end

    assign accept_c = req_i && ((state_q == IDLE) || (state_q == DONE));
    assign commit_c = ((state_q == WAIT) && (cnt_q == 4'd0)) || (ZERO_LAT && accept_c);

    // Next-state logic: accept, count down the latency, complete.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_c) begin
                    if (ZERO_LAT) state_d = DONE;
                    else          state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (commit_c) begin
            err_d = err_c;
            if (!cur_we) rdata_d = err_c ? 32'd0 : rd_word_c;
        end
    end

    // State, latched request and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Commit stores lane by lane. This path is gated by reset so that an
    // aborted store never reaches the array.
    always_ff @(posedge clk) begin
        if (reset && commit_c && cur_we && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) mem_q[idx_c][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign ready_o = (state_q == DONE);
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign busy_o  = req_i && !ready_o;

`ifdef UCSBECE154B_MEM_PERF_EN
    logic [31:0] perf_req_q;
    logic [31:0] perf_stall_q;

    // Count accepted requests and stall cycles; both wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_req_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_req_q   <= perf_req_q + {31'd0, accept_c};
            perf_stall_q <= perf_stall_q + {31'd0, busy_o};
        end
    end

    assign perf_req_o   = perf_req_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_mem_responder.sv
// Scoreboard bench for ucsbece154b_mem_responder. Instance 0 uses LATENCY=2
// and instance 1 uses LATENCY=0. Build with UCSBECE154B_MEM_PERF_EN defined to
// also check the performance counters.
module tb_ucsbece154b_mem_responder;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        t_rst;
    logic        t_req   [2];
    logic        t_we    [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [3:0]  t_be    [2];
    logic [31:0] o_rdata [2];
    logic        o_ready [2];
    logic        o_err   [2];
    logic        o_busy  [2];
`ifdef UCSBECE154B_MEM_PERF_EN
    logic [31:0] perf_req0, perf_stall0, perf_req1, perf_stall1;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    logic [31:0] b2b_val [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};

    always #5 clk = ~clk;

    ucsbece154b_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h1000_0000)) dut0 (
        .clk(clk), .reset(t_rst), .req_i(t_req[0]), .we_i(t_we[0]), .addr_i(t_addr[0]),
        .wdata_i(t_wdata[0]), .be_i(t_be[0]), .rdata_o(o_rdata[0]), .ready_o(o_ready[0]),
        .err_o(o_err[0]),
`ifdef UCSBECE154B_MEM_PERF_EN
        .perf_req_o(perf_req0), .perf_stall_o(perf_stall0),
`endif
        .busy_o(o_busy[0])
    );

    ucsbece154b_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0), .BASE_ADDR(32'h1000_0000)) dut1 (
        .clk(clk), .reset(t_rst), .req_i(t_req[1]), .we_i(t_we[1]), .addr_i(t_addr[1]),
        .wdata_i(t_wdata[1]), .be_i(t_be[1]), .rdata_o(o_rdata[1]), .ready_o(o_ready[1]),
        .err_o(o_err[1]),
`ifdef UCSBECE154B_MEM_PERF_EN
        .perf_req_o(perf_req1), .perf_stall_o(perf_stall1),
`endif
        .busy_o(o_busy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitors: pop one expectation for every ready pulse.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (o_ready[0] === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL mon0_unexpected: got ready=1 want no response pending");
            end else begin
                e = q0.pop_front();
                chk("mon0_err", {31'd0, o_err[0]}, {31'd0, e.err});
                if (e.chk_rd) chk("mon0_rdata", o_rdata[0], e.rd);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (o_ready[1] === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL mon1_unexpected: got ready=1 want no response pending");
            end else begin
                e = q1.pop_front();
                chk("mon1_err", {31'd0, o_err[1]}, {31'd0, e.err});
                if (e.chk_rd) chk("mon1_rdata", o_rdata[1], e.rd);
            end
        end
    end

    task automatic issue(input int s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, input logic push, input logic e_err,
                         input logic e_chk, input logic [31:0] e_rd);
        exp_t e;
        t_req[s] = 1'b1; t_we[s] = we; t_addr[s] = a; t_wdata[s] = wd; t_be[s] = b;
        e.err = e_err; e.chk_rd = e_chk; e.rd = e_rd;
        if (push) begin
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic wait_ready(input int s, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_ready[s] === 1'b1) begin
                n = i;
                return;
            end
        end
        total++; bad++;
        $display("FAIL wait_ready%0d: got timeout want ready pulse within 20 cycles", s);
    endtask

    // One isolated transaction; latency is counted in negedges after accept.
    task automatic xact(input int s, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input logic e_err, input logic e_chk,
                        input logic [31:0] e_rd);
        int n;
        @(negedge clk);
        issue(s, we, a, wd, b, 1'b1, e_err, e_chk, e_rd);
        @(posedge clk);
        wait_ready(s, n);
        t_req[s] = 1'b0;
        chk((s == 0) ? "lat2_cycles" : "lat0_cycles", n, (s == 0) ? 3 : 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got time limit want bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        t_rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            t_req[s] = 1'b0; t_we[s] = 1'b0; t_addr[s] = '0; t_wdata[s] = '0; t_be[s] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_rdata", o_rdata[s], 32'd0);
            chk("rst_ready", {31'd0, o_ready[s]}, 32'd0);
            chk("rst_err",   {31'd0, o_err[s]},   32'd0);
            chk("rst_busy",  {31'd0, o_busy[s]},  32'd0);
        end
        t_rst = 1'b1;

        // Prime word 0, then store with exact cycle-level timing checks.
        xact(0, 1'b1, 32'h1000_0000, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        issue(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'd0);
        #1 chk("t1_busy_T", {31'd0, o_busy[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t1_busy_T1",  {31'd0, o_busy[0]},  32'd1);
        chk("t1_ready_T1", {31'd0, o_ready[0]}, 32'd0);
        @(negedge clk);
        chk("t1_busy_T2",  {31'd0, o_busy[0]},  32'd1);
        chk("t1_ready_T2", {31'd0, o_ready[0]}, 32'd0);
        @(negedge clk);
        chk("t1_ready_T3", {31'd0, o_ready[0]}, 32'd1);
        chk("t1_busy_T3",  {31'd0, o_busy[0]},  32'd0);
        t_req[0] = 1'b0;
        @(negedge clk);
        chk("t1_ready_T4", {31'd0, o_ready[0]}, 32'd0);
        xact(0, 1'b0, 32'h1000_0010, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Partial-lane store over a known word.
        xact(0, 1'b1, 32'h1000_0040, 32'hAAAA_AAAA, 4'hF,    1'b0, 1'b0, 32'd0);
        xact(0, 1'b1, 32'h1000_0040, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 32'd0);
        xact(0, 1'b0, 32'h1000_0040, 32'd0,         4'hF,    1'b0, 1'b1, 32'hAA22_AA44);

        // Misaligned load, out-of-range store, array untouched.
        xact(0, 1'b0, 32'h1000_0002, 32'd0,         4'hF, 1'b1, 1'b1, 32'd0);
        xact(0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'd0);
        xact(0, 1'b1, 32'h1000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'd0);
        xact(0, 1'b0, 32'h1000_0000, 32'd0,         4'hF, 1'b0, 1'b1, 32'h0BAD_F00D);

        // Zero latency: fill four words, then four back-to-back loads.
        for (int i = 0; i < 4; i++)
            xact(1, 1'b1, 32'h1000_0100 + 32'(4 * i), b2b_val[i], 4'hF, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            issue(1, 1'b0, 32'h1000_0100 + 32'(4 * i), 32'd0, 4'hF, 1'b1, 1'b0, 1'b1, b2b_val[i]);
            @(posedge clk);
            wait_ready(1, n);
            chk("b2b_cycles", n, 1);
        end
        t_req[1] = 1'b0;

        // Reset one cycle after accepting a store; the old word must survive.
        xact(0, 1'b1, 32'h1000_0020, 32'hCAFE_0123, 4'hF, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        issue(0, 1'b1, 32'h1000_0020, 32'h5555_5555, 4'hF, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        t_rst = 1'b0;
        #1;
        chk("rstmid_ready", {31'd0, o_ready[0]}, 32'd0);
        chk("rstmid_rdata", o_rdata[0], 32'd0);
        t_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        t_rst = 1'b1;
        @(negedge clk);
        chk("rstrel_ready", {31'd0, o_ready[0]}, 32'd0);
        chk("rstrel_busy",  {31'd0, o_busy[0]},  32'd0);

        // Three clean loads after reset (also exercises the perf counters).
        xact(0, 1'b0, 32'h1000_0020, 32'd0, 4'hF, 1'b0, 1'b1, 32'hCAFE_0123);
        xact(0, 1'b0, 32'h1000_0010, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);
        xact(0, 1'b0, 32'h1000_0040, 32'd0, 4'hF, 1'b0, 1'b1, 32'hAA22_AA44);
        @(negedge clk);
`ifdef UCSBECE154B_MEM_PERF_EN
        chk("perf_req",   perf_req0,   32'd3);
        chk("perf_stall", perf_stall0, 32'd9);
`endif

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
